selevy_gout_uart: RTL and testbench

Downstream output stage for the selevy core. It samples the core's 4-bit `gout` on each rising edge of `out_clk` and buffers the nibbles in a small FIFO. Each nibble is sent as one ASCII hex character over an 8N1 UART transmit line, so program output is visible on a serial console or a bench UART monitor. It sits directly after `selevy` at the top level, in the same clock domain.

---
 rtl/selevy_gout_uart.sv | 193 +++++++++++++++++++
 tb/tb_selevy_gout_uart.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/selevy_gout_uart.sv
// selevy_gout_uart: output stage for the selevy core.
// Every rising edge of out_clk_i captures gout_i into a small nibble FIFO. Each
// queued nibble is sent as one uppercase ASCII hex character on an 8N1 UART line.
// Compile with SELEVY_UART_PARITY_EN defined to add an even-parity bit (8E1).
//
// Ports:
//   clk_i        system clock; all logic is on the rising edge
//   reset_ni     synchronous active-low reset
//   gout_i       4-bit output nibble from selevy
//   out_clk_i    output strobe from selevy, synchronous to clk_i
//   tx_o         UART serial data, idles high
//   busy_o       high while a frame is on the line
//   overflow_o   sticky: a capture was dropped because the FIFO was full
//   fifo_count_o number of occupied FIFO entries
module selevy_gout_uart #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [3:0]                    gout_i,
    input  logic                          out_clk_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned DivW = $clog2(CLK_DIV);

`ifdef SELEVY_UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    endfunction

    logic              out_clk_q;
    logic [3:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              overflow_q;
    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef SELEVY_UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic capture, pop, push, full, div_last;
    logic [7:0] head_ascii;

    // out_clk_q resets high so a strobe already high at reset release is ignored.
    assign capture    = out_clk_i & ~out_clk_q;
    assign pop        = (state_q == StIdle) && (count_q != '0);
    assign full       = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push lands in.
    assign push       = capture && (!full || pop);
    assign head_ascii = to_ascii(mem_q[rd_ptr_q]);
    assign div_last   = (div_q == DivW'(CLK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef SELEVY_UART_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d  = head_ascii;
`ifdef SELEVY_UART_PARITY_EN
                    parity_d = ^head_ascii;
`endif
                    tx_d     = 1'b0;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (div_last) begin
                    div_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StData: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef SELEVY_UART_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
`ifdef SELEVY_UART_PARITY_EN
            StParity: begin
                if (div_last) begin
                    div_d   = '0;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
`endif
            StStop: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            out_clk_q  <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef SELEVY_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            out_clk_q <= out_clk_i;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (capture && !push) overflow_q <= 1'b1;
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef SELEVY_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= gout_i;
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != StIdle);
    assign overflow_o   = overflow_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_selevy_gout_uart.sv
module tb_selevy_gout_uart;

    localparam int unsigned CD    = 4;
    localparam int unsigned DEPTH = 8;
`ifdef SELEVY_UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FL = NBITS * CD;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] gout = 4'h0;
    logic       out_clk = 1'b1;
    logic       tx, busy, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    selevy_gout_uart #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .gout_i       (gout),
        .out_clk_i    (out_clk),
        .tx_o         (tx),
        .busy_o       (busy),
        .overflow_o   (overflow),
        .fifo_count_o (fifo_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int unsigned starts[$];
    int unsigned blen[$];
    bit          dec_active = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference mapping: the character that prints the nibble in uppercase hex.
    function automatic logic [7:0] ascii_of(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    // Serial line decoder: samples each bit mid-period on the falling clock edge.
    initial begin
        int t;
        int unsigned b, start_cyc;
        logic [7:0] data;
        t = 0; start_cyc = 0; data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (tx === 1'b0) begin
                    dec_active = 1'b1;
                    t = 0;
                    start_cyc = cyc;
                end
            end else begin
                t++;
                if (t % CD == CD / 2) begin
                    b = t / CD;
                    if (b == 0) chk("start_bit", tx, 0);
                    else if (b <= 8) data[b-1] = tx;
                    else if (b == NBITS - 1) begin
                        chk("stop_bit", tx, 1);
                        rx_q.push_back(data);
                        starts.push_back(start_cyc);
                        dec_active = 1'b0;
                    end else chk("parity_bit", tx, ^data);
                end
            end
        end
    end

    // Length of each busy pulse.
    initial begin
        int unsigned len;
        len = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) len++;
            else if (len > 0) begin
                blen.push_back(len);
                len = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] n);
        gout = n;
        out_clk = 1'b1;
        tick();
        out_clk = 1'b0;
        gout = 4'($urandom);
        tick();
    endtask

    task automatic drain(input string tag, input bit check_gaps);
        int k;
        k = 0;
        while (!(busy === 1'b0 && fifo_count == 0 && !dec_active) && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, "_drain_in_time"}, 32'(k < 3000), 1);
        tick();
        tick();
        chk({tag, "_char_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_char%0d", tag, i), rx_q[i], exp_q[i]);
        for (int i = 0; i < blen.size(); i++)
            chk($sformatf("%s_busy_len%0d", tag, i), blen[i], FL);
        if (check_gaps)
            for (int i = 1; i < starts.size(); i++)
                chk($sformatf("%s_gap%0d", tag, i), starts[i] - starts[i-1], FL + 1);
        exp_q.delete();
        rx_q.delete();
        blen.delete();
        starts.delete();
    endtask

    initial begin
        logic [3:0] n, n0;
        logic [3:0] nibs[10];
        int peak;

        // Reset with the strobe already high.
        tick();
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", fifo_count, 0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("high_at_release_count", fifo_count, 0);
        chk("high_at_release_busy", busy, 0);
        out_clk = 1'b0;
        tick();

        // Single capture.
        gout = 4'hA;
        out_clk = 1'b1;
        tick();
        chk("cap_count", fifo_count, 1);
        chk("cap_tx_idle", tx, 1);
        chk("cap_busy", busy, 0);
        out_clk = 1'b0;
        tick();
        chk("start_tx_low", tx, 0);
        chk("start_busy", busy, 1);
        chk("start_count", fifo_count, 0);
        exp_q.push_back(ascii_of(4'hA));
        drain("single", 1'b0);

        // Digit mapping, queued back to back.
        pulse(4'h0); exp_q.push_back(ascii_of(4'h0));
        pulse(4'h9); exp_q.push_back(ascii_of(4'h9));
        pulse(4'hF); exp_q.push_back(ascii_of(4'hF));
        drain("digits", 1'b1);

        // Random nibbles with random spacing.
        repeat (5) begin
            n = 4'($urandom_range(0, 15));
            pulse(n);
            exp_q.push_back(ascii_of(n));
            repeat ($urandom_range(0, 6)) tick();
        end
        drain("random", 1'b0);

        // Overflow: first capture pops at once, DEPTH more are buffered, rest drop.
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            nibs[i] = 4'($urandom);
            pulse(nibs[i]);
            if (fifo_count > peak) peak = fifo_count;
        end
        chk("ovf_peak", peak, DEPTH);
        chk("ovf_count", fifo_count, DEPTH);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(ascii_of(nibs[i]));
        drain("overflow", 1'b1);
        chk("ovf_sticky", overflow, 1);

        // Strobe held high: one capture of the first-cycle nibble.
        n = 4'($urandom);
        gout = n;
        out_clk = 1'b1;
        tick();
        chk("held_count", fifo_count, 1);
        repeat (19) begin
            gout = 4'($urandom);
            tick();
        end
        out_clk = 1'b0;
        exp_q.push_back(ascii_of(n));
        drain("held", 1'b0);

        // Reset during data bit 3 with two entries queued.
        n0 = 4'($urandom);
        pulse(n0);
        pulse(4'($urandom));
        pulse(4'($urandom));
        chk("midrst_queued", fifo_count, 2);
        repeat (4 * CD + CD / 2 - 4) tick();
        n = 4'(ascii_of(n0) >> 3) & 4'h1;
        chk("midrst_bit3", tx, n);
        reset_n = 1'b0;
        tick();
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_overflow", overflow, 0);
        reset_n = 1'b1;
        repeat (3 * FL) tick();
        chk("midrst_no_frames", rx_q.size(), 0);
        chk("midrst_tx_idle", tx, 1);
        chk("midrst_busy_idle", busy, 0);
        rx_q.delete();
        blen.delete();
        starts.delete();

        // '3' has four ones: parity bit 0 when enabled, frame length checked in drain.
        pulse(4'h3);
        exp_q.push_back(ascii_of(4'h3));
        drain("parity", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
